// File: rtl/x_ram16_seq_pkg.sv
// Shared types and constants for the bit-serial RAM16 sequencer.
package x_ram16_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DEPTH      = 2**ADDR_W_DEF;
  localparam int unsigned CNT_W      = ADDR_W_DEF + 1;

  localparam logic CMD_LOAD = 1'b1;
  localparam logic CMD_READ = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    RESP
  } state_e;

endpackage

// File: rtl/x_ram16_sequencer_if.sv
// Command/response channel plus RAM16 primitive pins; slave = sequencer side.
interface x_ram16_sequencer_if
  import x_ram16_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  localparam int unsigned DEPTH_L = 2**ADDR_W;

  logic               CMD_VALID;
  logic               CMD_READY;
  logic               CMD_WR;
  logic [DEPTH_L-1:0] CMD_DATA;
  logic               RSP_VALID;
  logic               RSP_READY;
  logic [DEPTH_L-1:0] RSP_DATA;
  logic               RSP_ERR;
  logic [ADDR_W-1:0]  RAM_ADR;
  logic               RAM_WE;
  logic               RAM_I;
  logic               RAM_O;
  logic               BUSY;

  modport master (
    output CMD_VALID, CMD_WR, CMD_DATA, RSP_READY, RAM_O,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, RAM_ADR, RAM_WE, RAM_I, BUSY
  );

  modport slave (
    input  CMD_VALID, CMD_WR, CMD_DATA, RSP_READY, RAM_O,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, RAM_ADR, RAM_WE, RAM_I, BUSY
  );

endinterface

// File: rtl/x_ram16_seq_shreg.sv
// Shift/collect register: parallel load, rotate-right serial out (LSB first),
// and single-bit write at an index for collecting readback bits.
module x_ram16_seq_shreg #(
  parameter int unsigned W     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [W-1:0]     load_data,
  input  logic             rot_en,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             set_bit,
  output logic [W-1:0]     q,
  output logic             sout
);

  logic [W-1:0] word_q, word_d;

  // Rotating rather than shifting restores the word after W steps.
  always_comb begin
    word_d = word_q;
    if (load_en) begin
      word_d = load_data;
    end else begin
      if (rot_en) word_d = {word_q[0], word_q[W-1:1]};
      if (set_en) word_d[set_idx] = set_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign q    = word_q;
  assign sout = word_q[0];

endmodule

// File: rtl/x_ram16_sequencer.sv
// Bit-serial load/readback initiator for a 16x1 distributed RAM.
// Optional verify-after-load pass: define X_RAM16_SEQ_VERIFY_EN.
module x_ram16_sequencer
  import x_ram16_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_LAT = 0
) (
  input logic                 CLK,
  input logic                 RST_N,
  x_ram16_sequencer_if.slave  bus
);

  localparam int unsigned W    = 2**ADDR_W;
  localparam int unsigned CW   = ADDR_W + 1;
  localparam int unsigned PV_W = RD_LAT + 1;
  localparam int unsigned PI_W = PV_W * ADDR_W;
  localparam logic [CW-1:0] CNT_LAST   = CW'(W - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_adr_q, ram_adr_d;
  logic [PV_W-1:0]   pv_q, pv_d;
  logic [PI_W-1:0]   pi_q, pi_d;

  logic              accept;
  logic              rot_en;
  logic              samp_en;
  logic [ADDR_W-1:0] samp_idx;
  logic [W-1:0]      sh_word;
  logic              sh_sout;

  assign accept   = cmd_ready_q & bus.CMD_VALID;
  assign rot_en   = (state_q == WRITE);
  assign samp_en  = pv_q[PV_W-1];
  assign samp_idx = pi_q[PI_W-1 -: ADDR_W];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_adr_q   <= '0;
      pv_q        <= '0;
      pi_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      ram_we_q    <= ram_we_d;
      ram_adr_q   <= ram_adr_d;
      pv_q        <= pv_d;
      pi_q        <= pi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (bus.CMD_WR == CMD_LOAD) ? WRITE : READ;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef X_RAM16_SEQ_VERIFY_EN
          state_d = READ;
`else
          state_d = RESP;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READ: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (RD_LAT == 0) ? RESP : DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = RESP;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      RESP: begin
        if (bus.RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // edge on which the state is entered.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
    ram_we_d    = (state_d == WRITE);
    ram_adr_d   = ((state_d == WRITE) || (state_d == READ)) ? cnt_d[ADDR_W-1:0] : '0;
    pv_d        = PV_W'({pv_q, (state_d == READ)});
    pi_d        = PI_W'({pi_q, cnt_d[ADDR_W-1:0]});
  end

  x_ram16_seq_shreg #(
    .W     (W),
    .IDX_W (ADDR_W)
  ) u_shreg (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load_en   (accept),
    .load_data (bus.CMD_DATA),
    .rot_en    (rot_en),
    .set_en    (samp_en),
    .set_idx   (samp_idx),
    .set_bit   (bus.RAM_O),
    .q         (sh_word),
    .sout      (sh_sout)
  );

`ifdef X_RAM16_SEQ_VERIFY_EN
  logic vfy_q, vfy_d;
  logic err_q, err_d;

  // The word is still intact at each bit's sample point, so compare in place.
  always_comb begin
    vfy_d = vfy_q;
    err_d = err_q;
    if (accept) begin
      vfy_d = (bus.CMD_WR == CMD_LOAD);
      err_d = 1'b0;
    end else if (vfy_q && samp_en && (bus.RAM_O != sh_word[samp_idx])) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vfy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vfy_q <= vfy_d;
      err_q <= err_d;
    end
  end

  assign bus.RSP_ERR = err_q;
`else
  assign bus.RSP_ERR = 1'b0;
`endif

  assign bus.CMD_READY = cmd_ready_q;
  assign bus.BUSY      = busy_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = sh_word;
  assign bus.RAM_WE    = ram_we_q;
  assign bus.RAM_ADR   = ram_adr_q;
  assign bus.RAM_I     = sh_sout;

endmodule

// File: tb/tb_x_ram16_sequencer.sv
// Directed bench for x_ram16_sequencer with a behavioural 16x1 RAM and
// RD_LAT=2 output flops; checks under X_RAM16_SEQ_VERIFY_EN when defined.
`timescale 1ns/1ps
module tb_x_ram16_sequencer;
  import x_ram16_seq_pkg::*;

  localparam int unsigned TB_RD_LAT = 2;
`ifdef X_RAM16_SEQ_VERIFY_EN
  localparam int unsigned LAT_LOAD = 2*DEPTH + TB_RD_LAT;
`else
  localparam int unsigned LAT_LOAD = DEPTH;
`endif
  localparam int unsigned LAT_READ = DEPTH + TB_RD_LAT;
  localparam int unsigned WAIT_MAX = 1 << (CNT_W + 3);
  localparam int          NV       = 8;

  typedef struct {
    logic             wr;
    logic [DEPTH-1:0] data;
    logic             pre_en;
    logic [DEPTH-1:0] pre;
    logic [DEPTH-1:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs [NV];

  x_ram16_sequencer_if #(.ADDR_W(ADDR_W_DEF)) bus ();

  x_ram16_sequencer #(
    .ADDR_W (ADDR_W_DEF),
    .RD_LAT (TB_RD_LAT)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DEPTH-1:0] mem     = '0;
  logic [DEPTH-1:0] stuck0  = '0;
  logic [DEPTH-1:0] pre_val = '0;
  logic             pre_req = 1'b0;
  logic             o_raw, o_p1, o_p2;

  always @(posedge clk) begin
    if (pre_req)         mem <= pre_val;
    else if (bus.RAM_WE) mem[bus.RAM_ADR] <= bus.RAM_I;
  end
  assign o_raw = mem[bus.RAM_ADR] & ~stuck0[bus.RAM_ADR];
  always @(posedge clk) begin
    o_p1 <= o_raw;
    o_p2 <= o_p1;
  end
  assign bus.RAM_O = o_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [DEPTH-1:0] v);
    pre_val = v;
    pre_req = 1'b1;
    @(posedge clk); #1;
    pre_req = 1'b0;
  endtask

  task automatic run_cmd(input logic wr, input logic [DEPTH-1:0] data,
                         output int unsigned lat, output logic [DEPTH-1:0] rdata,
                         output logic rerr, output int unsigned we_cyc,
                         output logic adr_ok, output logic tmo);
    lat = 0; we_cyc = 0; adr_ok = 1'b1; tmo = 1'b0; rdata = '0; rerr = 1'b0;
    bus.CMD_WR = wr; bus.CMD_DATA = data; bus.CMD_VALID = 1'b1; bus.RSP_READY = 1'b0;
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    while (!bus.RSP_VALID && !tmo) begin
      if (bus.RAM_WE) begin
        if (bus.RAM_ADR != 4'(we_cyc)) adr_ok = 1'b0;
        we_cyc++;
      end
      @(posedge clk); #1;
      lat++;
      if (lat >= WAIT_MAX) tmo = 1'b1;
    end
    rdata = bus.RSP_DATA;
    rerr  = bus.RSP_ERR;
    bus.RSP_READY = 1'b1;
    @(posedge clk); #1;
    bus.RSP_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned      lat, we_cyc, nv;
    logic [DEPTH-1:0] rdata, held;
    logic             rerr, adr_ok, tmo;

    vecs[0] = '{CMD_LOAD, 16'hA5C3, 1'b0, 16'h0000, 16'hA5C3};
    vecs[1] = '{CMD_READ, 16'h0000, 1'b1, 16'h1234, 16'h1234};
    vecs[2] = '{CMD_LOAD, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{CMD_READ, 16'hFFFF, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{CMD_LOAD, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF};
    vecs[5] = '{CMD_READ, 16'h0000, 1'b1, 16'h8001, 16'h8001};
    vecs[6] = '{CMD_LOAD, 16'h3C96, 1'b0, 16'h0000, 16'h3C96};
    vecs[7] = '{CMD_READ, 16'h0000, 1'b0, 16'h0000, 16'h3C96};

    bus.CMD_VALID = 1'b0; bus.CMD_WR = 1'b0; bus.CMD_DATA = '0; bus.RSP_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst cmd_ready", bus.CMD_READY, 1);
    check("rst rsp_valid", bus.RSP_VALID, 0);
    check("rst ram_we",    bus.RAM_WE, 0);
    check("rst ram_adr",   bus.RAM_ADR, 0);
    check("rst rsp_data",  bus.RSP_DATA, 0);
    check("rst busy",      bus.BUSY, 0);
    check("rst rsp_err",   bus.RSP_ERR, 0);
    check("rst ram_i",     bus.RAM_I, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle cmd_ready", bus.CMD_READY, 1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre_en) preload(vecs[i].pre);
      run_cmd(vecs[i].wr, vecs[i].data, lat, rdata, rerr, we_cyc, adr_ok, tmo);
      check($sformatf("vec%0d timeout", i),   tmo, 0);
      check($sformatf("vec%0d rsp_data", i),  rdata, vecs[i].exp);
      check($sformatf("vec%0d latency", i),   lat, (vecs[i].wr == CMD_LOAD) ? LAT_LOAD : LAT_READ);
      check($sformatf("vec%0d we_cycles", i), we_cyc, (vecs[i].wr == CMD_LOAD) ? DEPTH : 0);
      check($sformatf("vec%0d adr_seq", i),   adr_ok, 1);
      check($sformatf("vec%0d rsp_err", i),   rerr, 0);
      check($sformatf("vec%0d ram_model", i), mem, vecs[i].exp);
      check($sformatf("vec%0d hs ready", i),  bus.CMD_READY, 1);
      check($sformatf("vec%0d hs valid", i),  bus.RSP_VALID, 0);
    end

    // Response held under backpressure while a new command is offered.
    bus.CMD_WR = CMD_LOAD; bus.CMD_DATA = 16'h5A5A; bus.CMD_VALID = 1'b1;
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    tmo = 1'b1;
    for (int c = 0; c < WAIT_MAX; c++) begin
      if (bus.RSP_VALID) begin tmo = 1'b0; break; end
      @(posedge clk); #1;
    end
    check("hold wait", tmo, 0);
    held = bus.RSP_DATA;
    check("hold first data", held, 16'h5A5A);
    bus.CMD_WR = CMD_READ; bus.CMD_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d valid", c), bus.RSP_VALID, 1);
      check($sformatf("hold%0d data", c),  bus.RSP_DATA, 16'h5A5A);
      check($sformatf("hold%0d ready", c), bus.CMD_READY, 0);
    end
    bus.RSP_READY = 1'b1;
    @(posedge clk); #1;
    bus.RSP_READY = 1'b0;
    check("hold hs cmd_ready", bus.CMD_READY, 1);
    check("hold hs rsp_valid", bus.RSP_VALID, 0);
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    check("hold next busy",  bus.BUSY, 1);
    check("hold next ready", bus.CMD_READY, 0);
    tmo = 1'b1;
    for (int c = 0; c < WAIT_MAX; c++) begin
      if (bus.RSP_VALID) begin tmo = 1'b0; break; end
      @(posedge clk); #1;
    end
    check("hold rb wait", tmo, 0);
    check("hold rb data", bus.RSP_DATA, 16'h5A5A);
    bus.RSP_READY = 1'b1;
    @(posedge clk); #1;
    bus.RSP_READY = 1'b0;

    // Reset in the middle of a load: no rollback of written cells.
    preload(16'h0000);
    bus.CMD_WR = CMD_LOAD; bus.CMD_DATA = 16'hFFFF; bus.CMD_VALID = 1'b1;
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("rstmid adr7", bus.RAM_ADR, 7);
    check("rstmid we",   bus.RAM_WE, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid we drop",    bus.RAM_WE, 0);
    check("rstmid rsp_valid",  bus.RSP_VALID, 0);
    check("rstmid busy",       bus.BUSY, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid model", mem, 16'h007F);
    check("rstmid ready", bus.CMD_READY, 1);

`ifdef X_RAM16_SEQ_VERIFY_EN
    stuck0[3] = 1'b1;
    run_cmd(CMD_LOAD, 16'h000F, lat, rdata, rerr, we_cyc, adr_ok, tmo);
    check("vfy timeout", tmo, 0);
    check("vfy rsp_err", rerr, 1);
    check("vfy data",    rdata, 16'h0007);
    check("vfy latency", lat, 2*DEPTH + TB_RD_LAT);
    stuck0[3] = 1'b0;
`endif

    // Back-to-back load then readback with RSP_READY tied high.
    bus.RSP_READY = 1'b1;
    bus.CMD_WR = CMD_LOAD; bus.CMD_DATA = 16'h0001; bus.CMD_VALID = 1'b1;
    @(posedge clk); #1;
    bus.CMD_WR = CMD_READ; bus.CMD_DATA = 16'hFFFF;
    nv = 0; rdata = '0; tmo = 1'b1;
    for (int c = 0; c < WAIT_MAX; c++) begin
      @(posedge clk); #1;
      if (bus.RSP_VALID) begin nv++; rdata = bus.RSP_DATA; end
      if (bus.CMD_READY) begin tmo = 1'b0; break; end
    end
    check("b2b load wait",   tmo, 0);
    check("b2b valid cycles", nv, 1);
    check("b2b load data",   rdata, 16'h0001);
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    check("b2b accept gap", bus.BUSY, 1);
    lat = 0; tmo = 1'b0;
    while (!bus.RSP_VALID && !tmo) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= WAIT_MAX) tmo = 1'b1;
    end
    check("b2b read wait",    tmo, 0);
    check("b2b read latency", lat, LAT_READ);
    check("b2b read data",    bus.RSP_DATA, 16'h0001);
    @(posedge clk); #1;
    check("b2b read hs", bus.CMD_READY, 1);
    bus.RSP_READY = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
